// File: rtl/gba_line_fetch_if.sv
// Scanline fetcher bus: line request/swap control, frame-memory read port, and column read-out.
// No latency of its own; flow control is implicit (busy/overrun), there is no ready/backpressure path.
// The master side drives requests, memory data and read-out columns; the slave side is the fetcher.
interface gba_line_fetch_if;
    logic        line_start;
    logic [7:0]  line_num;
    logic        swap;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [15:0] vgac_addr;
    logic [15:0] vgac_data;
    logic        rd_valid;
    logic [9:0]  rd_x;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;

    modport master (
        output line_start, line_num, swap, vgac_data, rd_valid, rd_x,
        input  busy, done, overrun, vgac_addr, R, G, B
    );

    modport slave (
        input  line_start, line_num, swap, vgac_data, rd_valid, rd_x,
        output busy, done, overrun, vgac_addr, R, G, B
    );
endinterface

// File: rtl/gba_line_fetch.sv
// Ping-pong GBA line buffer: fetches one BGR555 row from frame memory, serves the front row as RGB888 (GBA_LINE_FETCH_HDOUBLE_EN doubles columns).
// Latency: done 1+H_PIX+RD_LAT cycles after line_start; read-out is registered, 1 cycle.
// Backpressure: none; requests (line_start/swap) arriving while busy are dropped and raise sticky overrun.
module gba_line_fetch #(
    parameter int unsigned H_PIX     = 240,
    parameter int unsigned V_PIX     = 160,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    gba_line_fetch_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam int unsigned AW         = $clog2(2 * H_PIX);
    localparam logic [7:0]  X_LAST     = 8'(H_PIX - 1);
    localparam logic [1:0]  DRAIN_LAST = 2'(RD_LAT - 1);
`ifdef GBA_LINE_FETCH_HDOUBLE_EN
    localparam logic [9:0]  RD_LIMIT   = 10'(2 * H_PIX);
`else
    localparam logic [9:0]  RD_LIMIT   = 10'(H_PIX);
`endif

    state_t      state, state_nxt;
    logic [15:0] row_base, row_base_nxt;
    logic [7:0]  x, x_nxt;
    logic [1:0]  drain_cnt, drain_cnt_nxt;
    logic        black, black_nxt;
    logic        front_sel, front_sel_nxt;
    logic        done_q, done_nxt;
    logic        overrun_q, overrun_nxt;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_base  <= 16'h0000;
            x         <= 8'd0;
            drain_cnt <= 2'd0;
            black     <= 1'b0;
            front_sel <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            row_base  <= row_base_nxt;
            x         <= x_nxt;
            drain_cnt <= drain_cnt_nxt;
            black     <= black_nxt;
            front_sel <= front_sel_nxt;
            done_q    <= done_nxt;
            overrun_q <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        row_base_nxt  = row_base;
        x_nxt         = x;
        drain_cnt_nxt = drain_cnt;
        black_nxt     = black;
        front_sel_nxt = front_sel;
        done_nxt      = 1'b0;
        overrun_nxt   = overrun_q;
        case (state)
            IDLE: begin
                // A swap in the same cycle as line_start retargets the fetch at the old front.
                if (bus.swap) begin
                    front_sel_nxt = ~front_sel;
                end
                if (bus.line_start) begin
                    row_base_nxt = BASE_ADDR + 16'(bus.line_num) * 16'(H_PIX);
                    black_nxt    = (32'(bus.line_num) >= V_PIX);
                    x_nxt        = 8'd0;
                    state_nxt    = FETCH;
                end
            end
            FETCH: begin
                x_nxt = x + 8'd1;
                if (x == X_LAST) begin
                    drain_cnt_nxt = 2'd0;
                    state_nxt     = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    drain_cnt_nxt = drain_cnt + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if ((state != IDLE) && (bus.line_start || bus.swap)) begin
            overrun_nxt = 1'b1;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.overrun   = overrun_q;
    assign bus.vgac_addr = (state == FETCH) ? (row_base + 16'(x)) : 16'h0000;

    // ---------------- write-address pipeline (matches memory read latency) ----------------
    logic       pipe_vld [RD_LAT];
    logic [7:0] pipe_x   [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_vld[i] <= 1'b0;
            end
        end else begin
            pipe_vld[0] <= (state == FETCH);
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_x[0] <= x;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_x[i] <= pipe_x[i-1];
        end
    end

    // Both rows share one array: entries [0,H_PIX) are buffer 0, [H_PIX,2*H_PIX) buffer 1.
    logic [15:0]   line_mem [2 * H_PIX];
    logic          wr_vld;
    logic [15:0]   wr_dat;
    logic [AW-1:0] wr_idx;

    assign wr_vld = pipe_vld[RD_LAT-1];
    assign wr_dat = black ? 16'h0000 : bus.vgac_data;
    assign wr_idx = front_sel ? AW'(pipe_x[RD_LAT-1])
                              : AW'(H_PIX) + AW'(pipe_x[RD_LAT-1]);

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            line_mem[wr_idx] <= wr_dat;
        end
    end

    // ---------------- front-buffer read-out ----------------
    logic [9:0]    idx;
    logic          rd_ok;
    logic [AW-1:0] rd_idx;
    logic [15:0]   pix;
    logic [7:0]    r_q, g_q, b_q;

    always_comb begin
`ifdef GBA_LINE_FETCH_HDOUBLE_EN
        idx = {1'b0, bus.rd_x[9:1]};
`else
        idx = bus.rd_x;
`endif
        rd_ok  = bus.rd_valid && (bus.rd_x < RD_LIMIT);
        rd_idx = '0;
        if (rd_ok) begin
            rd_idx = front_sel ? AW'(H_PIX) + AW'(idx) : AW'(idx);
        end
    end

    assign pix = line_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 8'h00;
            g_q <= 8'h00;
            b_q <= 8'h00;
        end else if (rd_ok) begin
            r_q <= {pix[4:0],   pix[4:2]};
            g_q <= {pix[9:5],   pix[9:7]};
            b_q <= {pix[14:10], pix[14:12]};
        end else begin
            r_q <= 8'h00;
            g_q <= 8'h00;
            b_q <= 8'h00;
        end
    end

    assign bus.R = r_q;
    assign bus.G = g_q;
    assign bus.B = b_q;

    // Bit 15 of a BGR555 halfword carries no colour; column LSB only matters without doubling.
    logic unused_bits;
    assign unused_bits = ^{pix[15], idx[9], bus.rd_x[0]};

endmodule

// File: tb/tb_gba_line_fetch.sv
// Directed bench for gba_line_fetch: fetch timing, colour expansion, overrun, black rows, reset abort, address wrap.
module tb_gba_line_fetch;

`ifdef GBA_LINE_FETCH_HDOUBLE_EN
    localparam int TB_RD_LAT = 3;
    localparam int PX5       = 10;
    localparam int PX100     = 200;
`else
    localparam int TB_RD_LAT = 1;
    localparam int PX5       = 5;
    localparam int PX100     = 100;
`endif
    localparam int H   = 240;
    localparam int LAT = 1 + H + TB_RD_LAT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gba_line_fetch_if bus ();
    gba_line_fetch_if bus_w ();

    gba_line_fetch #(.H_PIX(240), .V_PIX(160), .BASE_ADDR(16'h0000), .RD_LAT(TB_RD_LAT))
        dut (.clk(clk), .rst(rst), .bus(bus));

    gba_line_fetch #(.H_PIX(240), .V_PIX(160), .BASE_ADDR(16'hFFF0), .RD_LAT(TB_RD_LAT))
        dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    // Frame memory model: data = address, returned TB_RD_LAT cycles later.
    logic [15:0] mem_pipe [TB_RD_LAT];
    always @(posedge clk) begin
        mem_pipe[0] <= bus.vgac_addr;
        for (int i = 1; i < TB_RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign bus.vgac_data   = mem_pipe[TB_RD_LAT-1];
    assign bus_w.vgac_data = 16'h0000;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_px(input int col, input logic vld, input string tag, input logic [23:0] exp);
        bus.rd_valid = vld;
        bus.rd_x     = 10'(col);
        tick;
        check(tag, {8'h00, bus.R, bus.G, bus.B}, {8'h00, exp});
    endtask

    // Issue line_start now (cycle N) and check cycles N+1..N+LAT+2; optional collision at cycle N+inj_k.
    task automatic run_fetch(input logic [7:0] num, input logic [15:0] first, input int inj_k, input logic ovr0);
        logic [15:0] exp_addr;
        bus.line_num   = num;
        bus.line_start = 1'b1;
        tick;
        bus.line_start = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            exp_addr = (k <= H) ? first + 16'(k - 1) : 16'h0000;
            check("addr", 32'(bus.vgac_addr), 32'(exp_addr));
            check("busy", 32'(bus.busy), 32'(k <= LAT - 1));
            check("done", 32'(bus.done), 32'(k == LAT));
            check("ovr",  32'(bus.overrun), 32'(ovr0 || (inj_k > 0 && k > inj_k)));
            if (k == inj_k) begin
                bus.line_num   = 8'd9;
                bus.line_start = 1'b1;
                bus.swap       = 1'b1;
            end
            tick;
            if (k == inj_k) begin
                bus.line_start = 1'b0;
                bus.swap       = 1'b0;
            end
        end
    endtask

    task automatic do_swap;
        bus.swap = 1'b1;
        tick;
        bus.swap = 1'b0;
    endtask

    int done_cnt;

    initial begin
        rst = 1'b1;
        bus.line_start = 1'b0;  bus.line_num = 8'd0;  bus.swap = 1'b0;
        bus.rd_valid   = 1'b0;  bus.rd_x     = 10'd0;
        bus_w.line_start = 1'b0; bus_w.line_num = 8'd0; bus_w.swap = 1'b0;
        bus_w.rd_valid   = 1'b0; bus_w.rd_x     = 10'd0;
        repeat (3) tick;
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_ovr",  32'(bus.overrun), 0);
        check("rst_addr", 32'(bus.vgac_addr), 0);
        check("rst_rgb",  {8'h00, bus.R, bus.G, bus.B}, 0);
        tick;

        // Line 3: addresses 720..959, pixel 5 = 0x02D5.
        run_fetch(8'd3, 16'd720, 0, 1'b0);
        do_swap;
`ifdef GBA_LINE_FETCH_HDOUBLE_EN
        rd_px(10,  1'b1, "hd_col10",  24'hADB500);
        rd_px(11,  1'b1, "hd_col11",  24'hADB500);
        rd_px(480, 1'b1, "hd_col480", 24'h000000);
`else
        rd_px(5,   1'b1, "px5",   24'hADB500);
        rd_px(0,   1'b1, "px0",   24'h84B500);
        rd_px(239, 1'b1, "px239", 24'hFFEF00);
        rd_px(240, 1'b1, "px240", 24'h000000);
`endif
        rd_px(PX5, 1'b0, "no_vld", 24'h000000);

        // Line 7 with a colliding line_start+swap at cycle N+50.
        run_fetch(8'd7, 16'd1680, 50, 1'b0);
        check("ovr_hold", 32'(bus.overrun), 1);
        rd_px(PX5, 1'b1, "front_kept", 24'hADB500);
        bus.rd_valid = 1'b0;
        do_swap;
        rd_px(PX5, 1'b1, "line7_px5", 24'hADA508);
        bus.rd_valid = 1'b0;

        // Line 200 is beyond V_PIX: whole row must read black.
        run_fetch(8'd200, 16'd48000, 0, 1'b1);
        do_swap;
        for (int c = 0; c < H; c++) rd_px(c, 1'b1, "black", 24'h000000);
        bus.rd_valid = 1'b0;

        // Reset 60 cycles into a fetch.
        bus.line_num   = 8'd3;
        bus.line_start = 1'b1;
        tick;
        bus.line_start = 1'b0;
        repeat (59) tick;
        rst = 1'b1;
        tick;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_addr", 32'(bus.vgac_addr), 0);
        check("abort_ovr",  32'(bus.overrun), 0);
        check("abort_done", 32'(bus.done), 0);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < LAT + 10; k++) begin
            if (bus.done || bus.busy) done_cnt++;
            tick;
        end
        check("no_done_after_rst", done_cnt, 0);
        rd_px(PX100, 1'b1, "front_sel0", 24'hA5BD08);
        bus.rd_valid = 1'b0;

        // BASE_ADDR 0xFFF0, line 255: 0xFFF0 + 61200 wraps to 0xEF00.
        bus_w.line_num   = 8'd255;
        bus_w.line_start = 1'b1;
        tick;
        bus_w.line_start = 1'b0;
        check("wrap_addr0", 32'(bus_w.vgac_addr), 32'h0000EF00);
        check("wrap_busy",  32'(bus_w.busy), 1);
        tick;
        check("wrap_addr1", 32'(bus_w.vgac_addr), 32'h0000EF01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gba_line_fetch.md
Name: gba_line_fetch

Overview:
- Scanline fetcher between the frame memory's video read port (vgac_addr/vgac_data) and the VGA output stage.
- On request, reads one 240-pixel GBA row of BGR555 halfwords into the back half of a ping-pong line buffer.
- On swap, exposes that row as the front buffer, which the display stage reads by column as RGB888.
- Decouples memory read timing from pixel-clock scan-out.

Parameters:
- H_PIX, 240, pixels per line; halfwords fetched per request.
- V_PIX, 160, number of valid lines; line_num >= V_PIX fetches black.
- BASE_ADDR, 16'h0000, halfword address of pixel (0,0) in the video address space.
- RD_LAT, 1, fixed cycles from vgac_addr to valid vgac_data (1..3).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- line_start  in  1  single-cycle request to fetch line line_num into the back buffer.
- line_num  in  8  row index, sampled when line_start is accepted.
- swap  in  1  single-cycle request to exchange front and back buffers.
- busy  out  1  fetch in progress.
- done  out  1  one-cycle pulse when the back buffer is complete.
- overrun  out  1  sticky error flag; cleared only by rst.
- vgac_addr  out  16  halfword read address to frame memory.
- vgac_data  in  16  read data, valid RD_LAT cycles after its address.
- rd_valid  in  1  display-active qualifier for rd_x.
- rd_x  in  10  display column to read from the front buffer.
- R  out  8  red.
- G  out  8  green.
- B  out  8  blue.

Behaviour:
- Reset values:
  - R, G, B, vgac_addr, busy, done, overrun = 0.
  - front-select = 0, FSM = IDLE.
  - Buffer contents unspecified.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - vgac_addr driven 0.
  - On line_start, latch row_base = BASE_ADDR + line_num*H_PIX (16-bit, wraps mod 2^16), set x = 0, go to FETCH. busy rises the next cycle.
- FETCH:
  - vgac_addr = row_base + x; x increments every cycle.
  - After x = H_PIX-1 is issued, go to DRAIN.
  - Write address is x delayed RD_LAT cycles via a shift pipeline. Data is written into the back buffer on arrival.
- DRAIN:
  - Lasts RD_LAT cycles to capture the last data.
  - Then done = 1 for one cycle, busy = 0 in that same cycle, state returns to IDLE.
- Latency: line_start at cycle N gives done at cycle N+1+H_PIX+RD_LAT. busy is high for cycles N+1 .. N+H_PIX+RD_LAT.
- If latched line_num >= V_PIX, the fetch still runs the same cycles, but writes 0 instead of vgac_data.
- line_start while busy: ignored, overrun set.
- swap:
  - In IDLE (including the done cycle), toggles front-select on the next edge.
  - While busy: ignored, overrun set.
- swap and line_start in the same IDLE cycle: both accepted. The fetch targets the new back buffer, i.e. the old front.
- Read-out (1-cycle registered latency):
  - idx = rd_x.
  - If rd_valid && idx < H_PIX, output front[idx] expanded: R = {p[4:0],p[4:2]}, G = {p[9:5],p[9:7]}, B = {p[14:10],p[14:12]}. p[15] is ignored.
  - Otherwise R = G = B = 0.
- Read-out is independent of fetch; front and back buffers never alias.
- rst mid-fetch: aborts immediately, no done pulse, all reset values apply.

Optional Feature:
- Macro: GBA_LINE_FETCH_HDOUBLE_EN.
- Defined: horizontal 2x pixel doubling. idx = rd_x >> 1; valid range is rd_valid && rd_x < 2*H_PIX (0..479). Columns 2k and 2k+1 output the same pixel.
- Undefined: idx = rd_x, valid range rd_x < H_PIX, no doubling.

Test Plan:
- Memory model returns data = addr, RD_LAT = 1, BASE_ADDR = 0. Stimulus: line_start with line_num = 3 at cycle 10 -> vgac_addr runs 720..959 on cycles 11..250; busy high on cycles 11..251; done pulses at cycle 252; overrun = 0.
- After the previous scenario: swap, then rd_valid = 1 with rd_x = 5 -> next cycle R = 0xAD, G = 0xB5, B = 0x00 (p = 0x02D5). rd_x = 240 -> R = G = B = 0 (macro off).
- Stimulus: line_start at cycle 100, then line_start and swap again at cycle 150 -> both ignored, overrun = 1 and stays 1; done still at cycle 342.
- Stimulus: line_num = 200 -> back buffer all zero after swap, so R = G = B = 0 for rd_x = 0..239. Separately, line_num = 255 with BASE_ADDR = 16'hFFF0 -> addresses wrap mod 2^16 (first address 16'hEF00).
- Stimulus: rst asserted at cycle 60 of a fetch -> next cycle busy = 0, vgac_addr = 0, overrun = 0, front-select = 0; no done pulse follows.
- With GBA_LINE_FETCH_HDOUBLE_EN and RD_LAT = 3 -> line 3 done at N+244; rd_x = 10 and rd_x = 11 both output pixel 725; rd_x = 480 outputs black.
